univ_shift_reg: RTL and testbench
=================================

Name: univ_shift_reg

Overview:
- Parametrised universal register, the multi-bit successor of the single-bit D flip-flop.
- WIDTH-bit storage with hold, logical shift, rotate, arithmetic shift, parallel load and synchronous clear, selected per clock by a 3-bit mode code.
- Keeps the family's complementary outputs (Q/Qn) and the asynchronous active-low Reset and Preset.
- Sits in the register/datapath layer as the general-purpose storage and shift element.

Parameters:
- WIDTH, 8, number of stored bits (valid range 2 or more).
- PRESET_VALUE, {WIDTH{1'b1}}, value forced by asynchronous Preset.

Ports:
- Clock  input  1  rising-edge clock.
- Reset  input  1  asynchronous active-low reset; forces Q=0.
- Preset  input  1  asynchronous active-low preset; forces Q=PRESET_VALUE.
- En  input  1  clock enable; 0 means hold regardless of Mode.
- Mode  input  3  operation select (codes under Behaviour).
- D  input  WIDTH  parallel load data.
- SinR  input  1  serial input entering at the MSB on a logical shift right.
- SinL  input  1  serial input entering at the LSB on a logical shift left.
- Q  output  WIDTH  register contents.
- Qn  output  WIDTH  bitwise complement of Q, always.
- SoutR  output  1  equals Q[0] (bit shifted out on a right shift).
- SoutL  output  1  equals Q[WIDTH-1] (bit shifted out on a left shift).
- Zero  output  1  registered flag; 1 when Q==0.

Behaviour:
- One clock, Clock. Reset is asynchronous and active-low.
- Reset=0 takes effect immediately and independent of Clock:
  - Q=0, Qn=all ones, Zero=1.
  - Reset has priority over Preset.
- Preset=0 while Reset=1 takes effect immediately:
  - Q=PRESET_VALUE, Qn=~PRESET_VALUE.
  - Zero=(PRESET_VALUE==0).
- While either asynchronous input is low, clock edges are ignored.
- On release of Reset or Preset, the next rising edge with En=1 performs a normal operation. There is no extra latency.
- On a rising Clock edge with Reset=1, Preset=1 and En=0: all outputs hold.
- On a rising Clock edge with Reset=1, Preset=1 and En=1, Mode selects:
  - 000 hold: Q unchanged.
  - 001 shift right logical: Q <= {SinR, Q[WIDTH-1:1]}.
  - 010 shift left logical: Q <= {Q[WIDTH-2:0], SinL}.
  - 011 parallel load: Q <= D.
  - 100 rotate right: Q <= {Q[0], Q[WIDTH-1:1]}. Serial inputs are ignored.
  - 101 rotate left: Q <= {Q[WIDTH-2:0], Q[WIDTH-1]}. Serial inputs are ignored.
  - 110 arithmetic shift right: Q <= {Q[WIDTH-1], Q[WIDTH-1:1]}. The sign bit is replicated.
  - 111 synchronous clear: Q <= 0.
- Latency: Q, Qn, SoutR, SoutL and Zero all reflect the operation one edge after it is sampled.
- SoutR and SoutL are combinational taps of Q. Each shows the bit that the next shift in its direction will discard.
- Zero is registered alongside Q and computed from the next-state value, so it is never one cycle stale.
- Qn is stored in the same always block as Q as its complement; Q and Qn can never be equal.
- Repeated rotate: WIDTH consecutive rotates in the same direction restore the original value.
- Repeated arithmetic shift right: a negative value saturates to all ones; a non-negative value saturates to 0.
- Mode and D changing between edges have no effect. Only the value at the rising edge counts.
- Reset asserted mid-sequence (for example during a shift train) aborts immediately. The sequence does not resume after release.

Decomposition:
- Shared package univ_reg_pkg holds the mode code constants: MODE_HOLD, MODE_SHR, MODE_SHL, MODE_LOAD, MODE_ROR, MODE_ROL, MODE_ASR, MODE_CLR.
- One natural sub-module, univ_reg_cell: a single-bit 8:1 next-state mux feeding a flop with async Reset/Preset, producing Q and Qn.
  - The top level instantiates WIDTH cells, wires neighbour bits, the serial inputs and the MSB for ASR, and derives Zero and the serial outputs.

Test Plan (WIDTH=8, PRESET_VALUE=8'hFF):
- Reset=0 mid-clock, then Preset=0 with Reset still 0 -> Q=8'h00, Qn=8'hFF, Zero=1 immediately. Reset then dominates, so Q stays 00.
- Release both; En=1, Mode=011, D=8'hA5; one edge -> Q=A5, Qn=5A, Zero=0. Then En=0 with Mode=111 over 3 edges -> Q stays A5.
- From Q=A5, Mode=001 with SinR=1 -> D2; then Mode=010 with SinL=0 -> A4. Check SoutR/SoutL before each edge: 1/1, then 0/1.
- From Q=8'h81, Mode=100 for 8 edges -> sequence C0, 60, 30, 18, 0C, 06, 03, 81. Mode=101 for 1 edge -> 03.
- From Q=8'h90, Mode=110 for 3 edges -> C8, E4, F2. From 8'h40, 7 edges of ASR -> 00 with Zero=1 on the same edge.
- Preset=0 pulse between edges during a shift train -> Q=FF asynchronously, Qn=00. After release, one Mode=111 edge -> Q=00, Zero=1.

Source files
------------

// File: rtl/univ_reg_pkg.sv
// Shared mode codes for the universal shift register family.
package univ_reg_pkg;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_SHR  = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_LOAD = 3'b011;
    localparam logic [2:0] MODE_ROR  = 3'b100;
    localparam logic [2:0] MODE_ROL  = 3'b101;
    localparam logic [2:0] MODE_ASR  = 3'b110;
    localparam logic [2:0] MODE_CLR  = 3'b111;

endpackage

// File: rtl/univ_shift_reg_if.sv
// Control/data bundle of the universal shift register; master drives, slave is the register.
interface univ_shift_reg_if #(
    parameter int WIDTH = 8
);
    logic             En;
    logic [2:0]       Mode;
    logic [WIDTH-1:0] D;
    logic             SinR;
    logic             SinL;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] Qn;
    logic             SoutR;
    logic             SoutL;
    logic             Zero;

    modport master (
        output En, Mode, D, SinR, SinL,
        input  Q, Qn, SoutR, SoutL, Zero
    );

    modport slave (
        input  En, Mode, D, SinR, SinL,
        output Q, Qn, SoutR, SoutL, Zero
    );
endinterface

// File: rtl/univ_reg_cell.sv
// One storage bit: 8:1 next-state mux into a flop with async Reset/Preset and a stored complement.
module univ_reg_cell
    import univ_reg_pkg::*;
#(
    parameter logic PRESET_BIT = 1'b1
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Preset,
    input  logic       en,
    input  logic [2:0] mode,
    input  logic       d,
    input  logic       shr_in,
    input  logic       shl_in,
    input  logic       ror_in,
    input  logic       rol_in,
    input  logic       asr_in,
    output logic       q_reg,
    output logic       qn_reg,
    output logic       q_next
);

    always_comb begin
        q_next = q_reg;
        if (en) begin
            case (mode)
                MODE_HOLD: q_next = q_reg;
                MODE_SHR:  q_next = shr_in;
                MODE_SHL:  q_next = shl_in;
                MODE_LOAD: q_next = d;
                MODE_ROR:  q_next = ror_in;
                MODE_ROL:  q_next = rol_in;
                MODE_ASR:  q_next = asr_in;
                MODE_CLR:  q_next = 1'b0;
                default:   q_next = q_reg;
            endcase
        end
    end

    // Qn lives in the same flop group so Q and Qn cannot diverge.
    always_ff @(posedge Clock or negedge Reset or negedge Preset) begin
        if (!Reset) begin
            q_reg  <= 1'b0;
            qn_reg <= 1'b1;
        end else if (!Preset) begin
            q_reg  <= PRESET_BIT;
            qn_reg <= ~PRESET_BIT;
        end else begin
            q_reg  <= q_next;
            qn_reg <= ~q_next;
        end
    end

endmodule

// File: rtl/univ_shift_reg.sv
// WIDTH-bit universal register: hold/shift/rotate/ASR/load/clear with async Reset and Preset.
module univ_shift_reg
    import univ_reg_pkg::*;
#(
    parameter int               WIDTH        = 8,
    parameter logic [WIDTH-1:0] PRESET_VALUE = {WIDTH{1'b1}}
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   Preset,
    univ_shift_reg_if.slave        bus
);

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] qn_reg;
    logic [WIDTH-1:0] q_next;
    logic             zero_reg;

    // Source vectors: bit gi of each is what cell gi loads for that mode.
    logic [WIDTH-1:0] shr_src;
    logic [WIDTH-1:0] shl_src;
    logic [WIDTH-1:0] ror_src;
    logic [WIDTH-1:0] rol_src;
    logic [WIDTH-1:0] asr_src;

    assign shr_src = {bus.SinR,        q_reg[WIDTH-1:1]};
    assign shl_src = {q_reg[WIDTH-2:0], bus.SinL};
    assign ror_src = {q_reg[0],        q_reg[WIDTH-1:1]};
    assign rol_src = {q_reg[WIDTH-2:0], q_reg[WIDTH-1]};
    assign asr_src = {q_reg[WIDTH-1],  q_reg[WIDTH-1:1]};

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
            univ_reg_cell #(
                .PRESET_BIT (PRESET_VALUE[gi])
            ) u_cell (
                .Clock  (Clock),
                .Reset  (Reset),
                .Preset (Preset),
                .en     (bus.En),
                .mode   (bus.Mode),
                .d      (bus.D[gi]),
                .shr_in (shr_src[gi]),
                .shl_in (shl_src[gi]),
                .ror_in (ror_src[gi]),
                .rol_in (rol_src[gi]),
                .asr_in (asr_src[gi]),
                .q_reg  (q_reg[gi]),
                .qn_reg (qn_reg[gi]),
                .q_next (q_next[gi])
            );
        end
    endgenerate

    // Zero comes from the next-state value so it lands on the same edge as Q.
    always_ff @(posedge Clock or negedge Reset or negedge Preset) begin
        if (!Reset) begin
            zero_reg <= 1'b1;
        end else if (!Preset) begin
            zero_reg <= (PRESET_VALUE == '0);
        end else begin
            zero_reg <= (q_next == '0);
        end
    end

    assign bus.Q     = q_reg;
    assign bus.Qn    = qn_reg;
    assign bus.SoutR = q_reg[0];
    assign bus.SoutL = q_reg[WIDTH-1];
    assign bus.Zero  = zero_reg;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg: directed plan scenarios plus randomized traffic vs a model.
module tb_univ_shift_reg;

    localparam int W = 8;

    logic Clock;
    logic Reset;
    logic Preset;
    int   checks;
    int   failures;

    univ_shift_reg_if #(.WIDTH(W)) bus ();

    univ_shift_reg #(
        .WIDTH        (W),
        .PRESET_VALUE (8'hFF)
    ) dut (
        .Clock  (Clock),
        .Reset  (Reset),
        .Preset (Preset),
        .bus    (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Reference: next value straight from the operation definitions.
    function automatic logic [W-1:0] ref_next(logic [W-1:0] q, logic en, logic [2:0] mode,
                                              logic [W-1:0] d, logic sr, logic sl);
        logic [2*W-1:0] dbl;
        dbl = {q, q};
        if (!en) return q;
        case (mode)
            3'd0:    return q;
            3'd1:    return (q >> 1) | (sr ? 8'h80 : 8'h00);
            3'd2:    return (q << 1) | {7'd0, sl};
            3'd3:    return d;
            3'd4:    return dbl[W:1];
            3'd5:    return dbl[2*W-2:W-1];
            3'd6:    return W'($signed(q) >>> 1);
            default: return '0;
        endcase
    endfunction

    task automatic drive(input logic en, input logic [2:0] mode, input logic [W-1:0] d,
                         input logic sr, input logic sl);
        bus.En   = en;
        bus.Mode = mode;
        bus.D    = d;
        bus.SinR = sr;
        bus.SinL = sl;
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic load(input logic [W-1:0] v);
        drive(1'b1, 3'd3, v, 1'b0, 1'b0);
        tick();
        checks++;
        if (bus.Q !== v) begin
            failures++;
            $display("FAIL load: Q=%h expected %h", bus.Q, v);
        end
    endtask

    task automatic test_reset();
        drive(1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
        tick();
        tick();
        #2;
        Reset = 1'b0;
        #1;
        checks++;
        if ({bus.Q, bus.Qn, bus.Zero} !== {8'h00, 8'hFF, 1'b1}) begin
            failures++;
            $display("FAIL reset_async: Q=%h Qn=%h Zero=%b expected 00 ff 1", bus.Q, bus.Qn, bus.Zero);
        end
        Preset = 1'b0;
        #1;
        checks++;
        if ({bus.Q, bus.Qn, bus.Zero} !== {8'h00, 8'hFF, 1'b1}) begin
            failures++;
            $display("FAIL reset_over_preset: Q=%h Qn=%h Zero=%b expected 00 ff 1", bus.Q, bus.Qn, bus.Zero);
        end
        drive(1'b1, 3'd3, 8'h5C, 1'b0, 1'b0);
        tick();
        checks++;
        if (bus.Q !== 8'h00) begin
            failures++;
            $display("FAIL reset_ignores_clock: Q=%h expected 00", bus.Q);
        end
        $display("reset: Q=%h Qn=%h Zero=%b", bus.Q, bus.Qn, bus.Zero);
        @(negedge Clock);
        Reset  = 1'b1;
        Preset = 1'b1;
    endtask

    task automatic test_load_hold();
        drive(1'b1, 3'd3, 8'hA5, 1'b0, 1'b0);
        tick();
        checks++;
        if ({bus.Q, bus.Qn, bus.Zero} !== {8'hA5, 8'h5A, 1'b0}) begin
            failures++;
            $display("FAIL load_a5: Q=%h Qn=%h Zero=%b expected a5 5a 0", bus.Q, bus.Qn, bus.Zero);
        end
        $display("load: Q=%h", bus.Q);
        drive(1'b0, 3'd7, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({bus.Q, bus.Zero} !== {8'hA5, 1'b0}) begin
                failures++;
                $display("FAIL en_low_hold[%0d]: Q=%h Zero=%b expected a5 0", i, bus.Q, bus.Zero);
            end
            $display("hold en=0: Q=%h", bus.Q);
        end
    endtask

    task automatic test_shift();
        checks++;
        if ({bus.SoutR, bus.SoutL} !== 2'b11) begin
            failures++;
            $display("FAIL sout_a5: SoutR/L=%b%b expected 11", bus.SoutR, bus.SoutL);
        end
        drive(1'b1, 3'd1, 8'h00, 1'b1, 1'b1);
        tick();
        checks++;
        if (bus.Q !== 8'hD2) begin
            failures++;
            $display("FAIL shr: Q=%h expected d2", bus.Q);
        end
        checks++;
        if ({bus.SoutR, bus.SoutL} !== 2'b01) begin
            failures++;
            $display("FAIL sout_d2: SoutR/L=%b%b expected 01", bus.SoutR, bus.SoutL);
        end
        drive(1'b1, 3'd2, 8'h00, 1'b1, 1'b0);
        tick();
        checks++;
        if (bus.Q !== 8'hA4) begin
            failures++;
            $display("FAIL shl: Q=%h expected a4", bus.Q);
        end
        $display("shift: Q=%h", bus.Q);
    endtask

    task automatic test_rotate();
        logic [W-1:0] seq [8] = '{8'hC0, 8'h60, 8'h30, 8'h18, 8'h0C, 8'h06, 8'h03, 8'h81};
        load(8'h81);
        drive(1'b1, 3'd4, 8'h00, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (bus.Q !== seq[i]) begin
                failures++;
                $display("FAIL ror[%0d]: Q=%h expected %h", i, bus.Q, seq[i]);
            end
            $display("ror: Q=%h", bus.Q);
        end
        drive(1'b1, 3'd5, 8'h00, 1'b0, 1'b0);
        tick();
        checks++;
        if (bus.Q !== 8'h03) begin
            failures++;
            $display("FAIL rol: Q=%h expected 03", bus.Q);
        end
    endtask

    task automatic test_asr();
        logic [W-1:0] neg [3] = '{8'hC8, 8'hE4, 8'hF2};
        load(8'h90);
        drive(1'b1, 3'd6, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.Q !== neg[i]) begin
                failures++;
                $display("FAIL asr_neg[%0d]: Q=%h expected %h", i, bus.Q, neg[i]);
            end
        end
        load(8'h40);
        drive(1'b1, 3'd6, 8'h00, 1'b1, 1'b1);
        for (int i = 0; i < 7; i++) begin
            tick();
            checks++;
            if ({bus.Q, bus.Zero} !== {8'h40 >> (i + 1), (i == 6)}) begin
                failures++;
                $display("FAIL asr_pos[%0d]: Q=%h Zero=%b expected %h %b",
                         i, bus.Q, bus.Zero, 8'h40 >> (i + 1), (i == 6));
            end
        end
        $display("asr: Q=%h Zero=%b", bus.Q, bus.Zero);
    endtask

    task automatic test_preset();
        load(8'h3C);
        drive(1'b1, 3'd1, 8'h00, 1'b0, 1'b0);
        tick();
        tick();
        Preset = 1'b0;
        #1;
        checks++;
        if ({bus.Q, bus.Qn, bus.Zero} !== {8'hFF, 8'h00, 1'b0}) begin
            failures++;
            $display("FAIL preset_async: Q=%h Qn=%h Zero=%b expected ff 00 0", bus.Q, bus.Qn, bus.Zero);
        end
        @(negedge Clock);
        Preset = 1'b1;
        drive(1'b1, 3'd7, 8'h00, 1'b1, 1'b1);
        tick();
        checks++;
        if ({bus.Q, bus.Qn, bus.Zero} !== {8'h00, 8'hFF, 1'b1}) begin
            failures++;
            $display("FAIL clr_after_preset: Q=%h Qn=%h Zero=%b expected 00 ff 1", bus.Q, bus.Qn, bus.Zero);
        end
        $display("preset+clr: Q=%h Zero=%b", bus.Q, bus.Zero);
    endtask

    // Random traffic; inputs glitch between edges and reset occasionally aborts the train.
    task automatic test_random();
        logic [W-1:0] exp_q;
        logic         en;
        logic [2:0]   mode;
        logic [W-1:0] d;
        logic         sr;
        logic         sl;
        exp_q = bus.Q;
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom), 3'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 19) == 0) begin
                Reset = 1'b0;
                #1;
                exp_q = '0;
                checks++;
                if ({bus.Q, bus.Zero} !== {8'h00, 1'b1}) begin
                    failures++;
                    $display("FAIL rand_reset[%0d]: Q=%h Zero=%b expected 00 1", i, bus.Q, bus.Zero);
                end
                Reset = 1'b1;
            end
            @(negedge Clock);
            en   = ($urandom_range(0, 4) != 0);
            mode = 3'($urandom);
            d    = 8'($urandom);
            sr   = 1'($urandom);
            sl   = 1'($urandom);
            drive(en, mode, d, sr, sl);
            #1;
            checks++;
            if ({bus.SoutR, bus.SoutL} !== {exp_q[0], exp_q[W-1]}) begin
                failures++;
                $display("FAIL rand_sout[%0d]: SoutR/L=%b%b expected %b%b",
                         i, bus.SoutR, bus.SoutL, exp_q[0], exp_q[W-1]);
            end
            exp_q = ref_next(exp_q, en, mode, d, sr, sl);
            tick();
            checks++;
            if ({bus.Q, bus.Qn, bus.Zero} !== {exp_q, ~exp_q, (exp_q == '0)}) begin
                failures++;
                $display("FAIL rand_op[%0d]: Q=%h Qn=%h Zero=%b expected %h %h %b",
                         i, bus.Q, bus.Qn, bus.Zero, exp_q, ~exp_q, (exp_q == '0));
            end
            $display("rand[%0d]: en=%b mode=%0d d=%h sr=%b sl=%b -> Q=%h Zero=%b",
                     i, en, mode, d, sr, sl, bus.Q, bus.Zero);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        Reset    = 1'b1;
        Preset   = 1'b1;
        drive(1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
        test_reset();
        test_load_hold();
        test_shift();
        test_rotate();
        test_asr();
        test_preset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
